// File: rtl/sp_exec_unit.sv
// Execute stage: single-cycle ALU/AGU ops plus an iterative shifter, with a registered result.
// Optional multiplier for func 1001 is enabled by defining SP_EXEC_MUL_EN.
module sp_exec_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned SHIFT_STEP     = 1,
    parameter int unsigned REG_ADDR_WIDTH = 3
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [3:0]                func_i,
    input  logic [XLEN-1:0]           op_a_i,
    input  logic [XLEN-1:0]           op_b_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [XLEN-1:0]           result_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_o,
    output logic                      err_o,
    output logic                      busy_o
);

    localparam int unsigned ShAmtW = $clog2(XLEN);
    // One extra bit so SHIFT_STEP == XLEN is representable.
    localparam int unsigned RemW = ShAmtW + 1;
    localparam logic [RemW-1:0] StepMax = RemW'(SHIFT_STEP);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                    state_q, state_d;
    logic [XLEN-1:0]           sh_val_q, sh_val_d;
    logic [RemW-1:0]           sh_rem_q, sh_rem_d;
    logic                      sh_left_q, sh_left_d;
    logic [REG_ADDR_WIDTH-1:0] sh_rd_q, sh_rd_d;
    logic                      out_valid_q, out_valid_d;
    logic [XLEN-1:0]           result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      err_q, err_d;

    logic                      out_free;
    logic                      accept;
    logic                      is_shift;
    logic [RemW-1:0]           in_amt;
    logic [XLEN-1:0]           alu_res;
    logic                      alu_err;
    logic [RemW-1:0]           step_amt;
    logic [XLEN-1:0]           sh_stepped;

    assign out_free   = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == StIdle) && out_free;
    assign accept     = in_valid_i && in_ready_o;
    assign busy_o     = (state_q == StShift);

    // Shift codes are x1x0 with bit 2 set: 0100/1100 right, 0110/1110 left.
    assign is_shift = func_i[2] && !func_i[0];
    assign in_amt   = RemW'(op_b_i[ShAmtW-1:0]);

    assign step_amt   = (sh_rem_q > StepMax) ? StepMax : sh_rem_q;
    assign sh_stepped = sh_left_q ? (sh_val_q << step_amt) : (sh_val_q >> step_amt);

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (func_i)
            4'b0011, 4'b0001,
            4'b0010, 4'b1010: alu_res = op_a_i + op_b_i;
            4'b1011:          alu_res = op_a_i - op_b_i;
            4'b0101:          alu_res = op_a_i & op_b_i;
            4'b1101:          alu_res = op_a_i | op_b_i;
            4'b1111:          alu_res = op_a_i ^ op_b_i;
            4'b0111:          alu_res = ~op_a_i;
            // Zero-amount shifts complete here; nonzero ones go to the FSM.
            4'b0110, 4'b1110,
            4'b0100, 4'b1100: alu_res = op_a_i;
`ifdef SP_EXEC_MUL_EN
            4'b1001:          alu_res = op_a_i * op_b_i;
`endif
            default:          alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sh_val_d    = sh_val_q;
        sh_rem_d    = sh_rem_q;
        sh_left_d   = sh_left_q;
        sh_rd_d     = sh_rd_q;
        out_valid_d = out_valid_q && !out_ready_i;
        result_d    = result_q;
        rd_d        = rd_q;
        err_d       = err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_shift && (in_amt != '0)) begin
                        state_d   = StShift;
                        sh_val_d  = op_a_i;
                        sh_rem_d  = in_amt;
                        sh_left_d = func_i[1];
                        sh_rd_d   = rd_i;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        rd_d        = rd_i;
                        err_d       = alu_err;
                    end
                end
            end
            StShift: begin
                sh_val_d = sh_stepped;
                sh_rem_d = sh_rem_q - step_amt;
                // With remaining at 0 the shifter idles until the output register frees.
                if ((sh_rem_d == '0) && out_free) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    result_d    = sh_stepped;
                    rd_d        = sh_rd_q;
                    err_d       = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= StIdle;
            sh_val_q    <= '0;
            sh_rem_q    <= '0;
            sh_left_q   <= 1'b0;
            sh_rd_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_val_q    <= sh_val_d;
            sh_rem_q    <= sh_rem_d;
            sh_left_q   <= sh_left_d;
            sh_rd_q     <= sh_rd_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign rd_o        = rd_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sp_exec_unit.sv
// Directed bench for sp_exec_unit: vector table for single-cycle ops, sequences for shifts,
// back-pressure and reset. Two instances: SHIFT_STEP = 1 and SHIFT_STEP = 4.
module tb_sp_exec_unit;

    logic        clk;
    logic        arst;
    logic        in_valid;
    logic        v4_valid;
    logic [3:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  rd;
    logic        out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [31:0] result,    result4;
    logic [2:0]  rd_out,    rd_out4;
    logic        err,       err4;
    logic        busy,      busy4;

    int n_tests = 0;
    int n_fail  = 0;

    sp_exec_unit #(.XLEN(32), .SHIFT_STEP(1), .REG_ADDR_WIDTH(3)) dut (
        .clk_i(clk), .arst_i(arst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .func_i(func), .op_a_i(op_a), .op_b_i(op_b), .rd_i(rd),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .rd_o(rd_out), .err_o(err), .busy_o(busy)
    );

    sp_exec_unit #(.XLEN(32), .SHIFT_STEP(4), .REG_ADDR_WIDTH(3)) dut4 (
        .clk_i(clk), .arst_i(arst), .in_valid_i(v4_valid), .in_ready_o(in_ready4),
        .func_i(func), .op_a_i(op_a), .op_b_i(op_b), .rd_i(rd),
        .out_valid_o(out_valid4), .out_ready_i(out_ready), .result_o(result4),
        .rd_o(rd_out4), .err_o(err4), .busy_o(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  r;
        logic [31:0] res;
        logic        e;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_shift(input bit sel, input logic [3:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                             input string name);
        int lat;
        int bcnt;
        func = f; op_a = a; op_b = b; rd = 3'd6;
        if (sel) v4_valid = 1'b1; else in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        v4_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!(sel ? out_valid4 : out_valid) && lat < 100) begin
            if (sel ? busy4 : busy) bcnt++;
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy cycles"}, 32'(bcnt), 32'(exp_lat - 1));
        check({name, " result"}, sel ? result4 : result, exp);
        check({name, " rd"}, 32'(sel ? rd_out4 : rd_out), 32'd6);
        tick();
        check({name, " drained"}, 32'(sel ? out_valid4 : out_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{4'b0011, 32'hFFFF_FFFF, 32'd2,         3'd5, 32'h0000_0001, 1'b0};
        vecs[1]  = '{4'b1011, 32'd10,        32'd3,         3'd1, 32'd7,         1'b0};
        vecs[2]  = '{4'b1111, 32'h0000_F0F0, 32'h0000_0FF0, 3'd2, 32'h0000_FF00, 1'b0};
        vecs[3]  = '{4'b0111, 32'd0,         32'h1234_5678, 3'd3, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{4'b0001, 32'd5,         32'd6,         3'd4, 32'd11,        1'b0};
        vecs[5]  = '{4'b0101, 32'h0000_F0F0, 32'h0000_0FF0, 3'd7, 32'h0000_00F0, 1'b0};
        vecs[6]  = '{4'b1101, 32'h0000_F0F0, 32'h0000_0FF0, 3'd0, 32'h0000_FFF0, 1'b0};
        vecs[7]  = '{4'b0010, 32'h0000_0100, 32'd4,         3'd1, 32'h0000_0104, 1'b0};
        vecs[8]  = '{4'b1010, 32'h0000_1000, 32'hFFFF_FFFF, 3'd2, 32'h0000_0FFF, 1'b0};
        vecs[9]  = '{4'b0110, 32'h0000_1234, 32'd32,        3'd3, 32'h0000_1234, 1'b0};
        vecs[10] = '{4'b0100, 32'h8000_0000, 32'h20,        3'd4, 32'h8000_0000, 1'b0};
        vecs[11] = '{4'b0000, 32'd5,         32'd6,         3'd5, 32'd0,         1'b1};
        vecs[12] = '{4'b1000, 32'd5,         32'd6,         3'd6, 32'd0,         1'b1};
`ifdef SP_EXEC_MUL_EN
        vecs[13] = '{4'b1001, 32'd7,         32'd6,         3'd7, 32'd42,        1'b0};
`else
        vecs[13] = '{4'b1001, 32'd7,         32'd6,         3'd7, 32'd0,         1'b1};
`endif

        arst = 1'b1; in_valid = 1'b0; v4_valid = 1'b0; func = 4'b0; op_a = '0; op_b = '0;
        rd = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;

        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd", 32'(rd_out), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            func = vecs[i].f; op_a = vecs[i].a; op_b = vecs[i].b; rd = vecs[i].r;
            in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d rd", i), 32'(rd_out), 32'(vecs[i].r));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e));
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream drained", 32'(out_valid), 32'd0);

        run_shift(1'b0, 4'b0110, 32'd1,         32'd31,   32'h8000_0000, 32, "sll31 s1");
        run_shift(1'b0, 4'b0100, 32'h8000_0000, 32'h23,   32'h1000_0000, 4,  "slr3 s1");
        run_shift(1'b0, 4'b1110, 32'h0000_000F, 32'd4,    32'h0000_00F0, 5,  "slli4 s1");
        run_shift(1'b0, 4'b1100, 32'hFFFF_FFFF, 32'd8,    32'h00FF_FFFF, 9,  "slri8 s1");
        run_shift(1'b1, 4'b0110, 32'd1,         32'd31,   32'h8000_0000, 9,  "sll31 s4");
        run_shift(1'b1, 4'b0100, 32'hF000_0000, 32'd6,    32'h03C0_0000, 3,  "slr6 s4");

        // Held result with a shift pending at the input.
        out_ready = 1'b0;
        func = 4'b0011; op_a = 32'd2; op_b = 32'd3; rd = 3'd1; in_valid = 1'b1;
        tick();
        check("hold add result", result, 32'd5);
        func = 4'b0110; op_a = 32'd3; op_b = 32'd2; rd = 3'd2;
        for (int i = 0; i < 3; i++) begin
            check("hold in_ready", 32'(in_ready), 32'd0);
            tick();
            check("hold result stable", result, 32'd5);
            check("hold valid stable", 32'(out_valid), 32'd1);
            check("hold no busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("drain edge valid", 32'(out_valid), 32'd0);
        check("drain edge busy", 32'(busy), 32'd1);
        tick();
        check("shift mid valid", 32'(out_valid), 32'd0);
        tick();
        check("shift done valid", 32'(out_valid), 32'd1);
        check("shift done result", result, 32'd12);
        check("shift done rd", 32'(rd_out), 32'd2);
        out_ready = 1'b0;
        func = 4'b0111; op_a = 32'd0; rd = 3'd3; in_valid = 1'b1;
        repeat (2) tick();
        check("held shift result", result, 32'd12);
        check("held shift rd", 32'(rd_out), 32'd2);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("drain+load valid", 32'(out_valid), 32'd1);
        check("drain+load result", result, 32'hFFFF_FFFF);
        tick();
        check("final drain", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a shift discards the operation.
        func = 4'b0110; op_a = 32'd1; op_b = 32'd31; rd = 3'd4; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        arst = 1'b1;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset valid", 32'(out_valid), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        check("async reset result", result, 32'd0);
        #2 arst = 1'b0;
        cnt = 0;
        repeat (40) begin
            tick();
            if (out_valid || busy) cnt++;
        end
        check("no result after reset", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
